// File: rtl/input_loader.sv
// input_loader: accepts a stream of 32-bit beats forming one event, routes each word to
// one of two write-port memories by bit 31, then starts a downstream process and waits
// for its done before loading the next event.
// Optional feature: define LOADER_OVFL_CNT_EN to add the ovfl_cnt dropped-beat counter.
module input_loader #(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  input  logic [1:0]    s_bx,
  output logic          mem1_ena,
  output logic          mem1_wea,
  output logic [AW-1:0] mem1_writeaddr,
  output logic [31:0]   mem1_din,
  output logic          mem2_ena,
  output logic          mem2_wea,
  output logic [AW-1:0] mem2_writeaddr,
  output logic [31:0]   mem2_din,
  output logic          en_proc,
  output logic [1:0]    bx_o,
  input  logic          proc_done,
  output logic [AW:0]   nwords1,
  output logic [AW:0]   nwords2,
`ifdef LOADER_OVFL_CNT_EN
  output logic          overflow,
  output logic [7:0]    ovfl_cnt
`else
  output logic          overflow
`endif
);

  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  typedef enum logic [1:0] {StLoad, StFlush, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     cnt1_q, cnt2_q;
  logic            overflow_q;
  logic            first_q;
  logic [1:0]      bx_q;
  logic            wr1_q, wr2_q;
  logic [AW-1:0]   addr1_q, addr2_q;
  logic [31:0]     din1_q, din2_q;

  logic            accept;
  logic            sel2;
  logic            full;
  logic            clear_evt;

  assign accept    = s_valid & s_ready;
  assign sel2      = s_data[31];
  assign full      = sel2 ? (cnt2_q == FullCnt) : (cnt1_q == FullCnt);
  // Downstream done closes the event: counts and overflow restart for the next one.
  assign clear_evt = (state_q == StRun) & proc_done;

  // Next-state and handshake outputs; proc_done only matters while running.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    en_proc = 1'b0;
    unique case (state_q)
      StLoad: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = StFlush;
      end
      StFlush: state_d = StRun;
      StRun: begin
        en_proc = 1'b1;
        if (proc_done) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StLoad;
    else       state_q <= state_d;
  end

  // Registered write ports, per-memory counts, overflow flag and BX capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      overflow_q <= 1'b0;
      first_q    <= 1'b1;
      bx_q       <= '0;
      wr1_q      <= 1'b0;
      wr2_q      <= 1'b0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      din1_q     <= '0;
      din2_q     <= '0;
    end else begin
      wr1_q <= 1'b0;
      wr2_q <= 1'b0;
      if (clear_evt) begin
        cnt1_q     <= '0;
        cnt2_q     <= '0;
        overflow_q <= 1'b0;
        first_q    <= 1'b1;
      end else if (accept) begin
        first_q <= 1'b0;
        if (first_q) bx_q <= s_bx;
        // A beat to a full memory is consumed but dropped, so addresses never wrap.
        if (full) begin
          overflow_q <= 1'b1;
        end else if (sel2) begin
          wr2_q   <= 1'b1;
          addr2_q <= cnt2_q[AW-1:0];
          din2_q  <= s_data;
          cnt2_q  <= cnt2_q + 1'b1;
        end else begin
          wr1_q   <= 1'b1;
          addr1_q <= cnt1_q[AW-1:0];
          din1_q  <= s_data;
          cnt1_q  <= cnt1_q + 1'b1;
        end
      end
    end
  end

`ifdef LOADER_OVFL_CNT_EN
  logic [7:0] ovfl_cnt_q;

  // Dropped-beat count for the current event, saturating.
  always_ff @(posedge clk) begin
    if (reset || clear_evt) begin
      ovfl_cnt_q <= '0;
    end else if (accept && full && (ovfl_cnt_q != 8'hff)) begin
      ovfl_cnt_q <= ovfl_cnt_q + 8'd1;
    end
  end

  assign ovfl_cnt = ovfl_cnt_q;
`endif

  assign mem1_ena       = wr1_q;
  assign mem1_wea       = wr1_q;
  assign mem1_writeaddr = addr1_q;
  assign mem1_din       = din1_q;
  assign mem2_ena       = wr2_q;
  assign mem2_wea       = wr2_q;
  assign mem2_writeaddr = addr2_q;
  assign mem2_din       = din2_q;
  assign nwords1        = cnt1_q;
  assign nwords2        = cnt2_q;
  assign overflow       = overflow_q;
  assign bx_o           = bx_q;

endmodule

// File: tb/tb_input_loader.sv
// Self-checking bench for input_loader: a scoreboard queue holds the memory writes
// expected from each accepted beat and is drained as the write ports fire.
module tb_input_loader;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic [1:0]  s_bx;
  logic        mem1_ena, mem1_wea;
  logic [4:0]  mem1_writeaddr;
  logic [31:0] mem1_din;
  logic        mem2_ena, mem2_wea;
  logic [4:0]  mem2_writeaddr;
  logic [31:0] mem2_din;
  logic        en_proc;
  logic [1:0]  bx_o;
  logic        proc_done;
  logic [5:0]  nwords1, nwords2;
  logic        overflow;
`ifdef LOADER_OVFL_CNT_EN
  logic [7:0]  ovfl_cnt;
`endif

  input_loader #(.DEPTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_bx           (s_bx),
    .mem1_ena       (mem1_ena),
    .mem1_wea       (mem1_wea),
    .mem1_writeaddr (mem1_writeaddr),
    .mem1_din       (mem1_din),
    .mem2_ena       (mem2_ena),
    .mem2_wea       (mem2_wea),
    .mem2_writeaddr (mem2_writeaddr),
    .mem2_din       (mem2_din),
    .en_proc        (en_proc),
    .bx_o           (bx_o),
    .proc_done      (proc_done),
    .nwords1        (nwords1),
    .nwords2        (nwords2),
`ifdef LOADER_OVFL_CNT_EN
    .overflow       (overflow),
    .ovfl_cnt       (ovfl_cnt)
`else
    .overflow       (overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        m;     // 0: mem1, 1: mem2
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model of the current event.
  int         m_n1, m_n2, m_drop;
  logic       m_ovf, m_first;
  logic [1:0] m_bx;

  task automatic model_clear();
    m_n1 = 0; m_n2 = 0; m_drop = 0; m_ovf = 1'b0; m_first = 1'b1;
  endtask

  // Advance one clock and drain the scoreboard against the write ports.
  task automatic step();
    wr_t  e;
    logic gm;
    logic [4:0] ga;
    logic [31:0] gd;
    @(posedge clk);
    cyc++;
    #1;
    checks++;
    if (mem1_ena !== mem1_wea || mem2_ena !== mem2_wea || (mem1_ena === 1'b1 && mem2_ena === 1'b1)) begin
      errors++;
      $display("FAIL wr_enables cyc=%0d: got ena1=%b wea1=%b ena2=%b wea2=%b, want pairs equal, one port",
               cyc, mem1_ena, mem1_wea, mem2_ena, mem2_wea);
    end
    if (mem1_ena === 1'b1 || mem2_ena === 1'b1) begin
      gm = (mem2_ena === 1'b1);
      ga = gm ? mem2_writeaddr : mem1_writeaddr;
      gd = gm ? mem2_din : mem1_din;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d: got mem%0d addr=%0d din=%h, want no write",
                 cyc, gm + 1, ga, gd);
      end else begin
        e = q.pop_front();
        if (gm !== e.m || ga !== e.addr || gd !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write cyc=%0d: got mem%0d addr=%0d din=%h, want mem%0d addr=%0d din=%h cyc=%0d",
                   cyc, gm + 1, ga, gd, e.m + 1, e.addr, e.data, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_write cyc=%0d: got none, want mem%0d addr=%0d din=%h",
               cyc, e.m + 1, e.addr, e.data);
    end
  endtask

  // Drive one beat for one cycle (DUT must be in LOAD) and record the expected write.
  task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] bx);
    wr_t e;
    s_valid = 1'b1; s_data = d; s_last = last; s_bx = bx;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready: got s_ready=%b, want 1", s_ready);
    end
    if (m_first) begin m_bx = bx; m_first = 1'b0; end
    e.m = d[31]; e.data = d; e.cyc = cyc + 1;
    if (d[31]) begin
      if (m_n2 < 32) begin e.addr = m_n2[4:0]; q.push_back(e); m_n2++; end
      else begin m_ovf = 1'b1; m_drop++; end
    end else begin
      if (m_n1 < 32) begin e.addr = m_n1[4:0]; q.push_back(e); m_n1++; end
      else begin m_ovf = 1'b1; m_drop++; end
    end
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Pulse proc_done for one RUN cycle, returning the DUT to LOAD.
  task automatic end_event();
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_bx = '0; proc_done = 1'b0;
    step(); step();
    reset = 1'b0;
    model_clear(); m_bx = 2'd0;
    checks++;
    if (s_ready !== 1'b1 || en_proc !== 1'b0 || mem1_ena !== 1'b0 || mem2_ena !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b en=%b ena1=%b ena2=%b, want 1 0 0 0",
               s_ready, en_proc, mem1_ena, mem2_ena);
    end
    checks++;
    if (nwords1 !== 6'd0 || nwords2 !== 6'd0 || overflow !== 1'b0 || bx_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got n1=%0d n2=%0d ovf=%b bx=%0d, want 0 0 0 0",
               nwords1, nwords2, overflow, bx_o);
    end
    checks++;
    if (mem1_writeaddr !== 5'd0 || mem1_din !== 32'd0 || mem2_writeaddr !== 5'd0 || mem2_din !== 32'd0) begin
      errors++;
      $display("FAIL reset_port: got a1=%0d d1=%h a2=%0d d2=%h, want zeros",
               mem1_writeaddr, mem1_din, mem2_writeaddr, mem2_din);
    end
  endtask

  task automatic test_basic();
    proc_done = 1'b1;  // ignored while loading and flushing
    beat(32'h0000_0011, 1'b0, 2'd2);
    beat(32'h8000_0022, 1'b0, 2'd2);
    beat(32'h0000_0033, 1'b1, 2'd2);
    checks++;
    if (s_ready !== 1'b0 || en_proc !== 1'b0) begin
      errors++;
      $display("FAIL basic_flush: got ready=%b en=%b, want 0 0", s_ready, en_proc);
    end
    step();
    proc_done = 1'b0;
    checks++;
    if (en_proc !== 1'b1 || nwords1 !== 6'd2 || nwords2 !== 6'd1 || bx_o !== 2'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_run: got en=%b n1=%0d n2=%0d bx=%0d ovf=%b, want 1 2 1 2 0",
               en_proc, nwords1, nwords2, bx_o, overflow);
    end
  endtask

  task automatic test_run_hold();
    s_valid = 1'b1; s_data = 32'h0000_0055; s_bx = 2'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (s_ready !== 1'b0 || en_proc !== 1'b1 || nwords1 !== 6'd2 || nwords2 !== 6'd1) begin
        errors++;
        $display("FAIL run_hold[%0d]: got ready=%b en=%b n1=%0d n2=%0d, want 0 1 2 1",
                 i, s_ready, en_proc, nwords1, nwords2);
      end
    end
    s_valid = 1'b0;
    end_event();
    checks++;
    if (en_proc !== 1'b0 || s_ready !== 1'b1 || nwords1 !== 6'd0 || nwords2 !== 6'd0 || bx_o !== 2'd2) begin
      errors++;
      $display("FAIL run_release: got en=%b ready=%b n1=%0d n2=%0d bx=%0d, want 0 1 0 0 2",
               en_proc, s_ready, nwords1, nwords2, bx_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 34; i++) begin
      beat(i[31:0], (i == 33), 2'd1);
      if (i == 31 || i == 32) begin
        checks++;
        if (overflow !== m_ovf) begin
          errors++;
          $display("FAIL ovf_edge[%0d]: got overflow=%b, want %b", i, overflow, m_ovf);
        end
      end
    end
    step();
    checks++;
    if (nwords1 !== 6'd32 || nwords2 !== 6'd0 || overflow !== 1'b1 || en_proc !== 1'b1) begin
      errors++;
      $display("FAIL ovf_run: got n1=%0d n2=%0d ovf=%b en=%b, want 32 0 1 1",
               nwords1, nwords2, overflow, en_proc);
    end
`ifdef LOADER_OVFL_CNT_EN
    checks++;
    if (ovfl_cnt !== m_drop[7:0]) begin
      errors++;
      $display("FAIL ovfl_cnt: got %0d, want %0d", ovfl_cnt, m_drop);
    end
`endif
    end_event();
    checks++;
    if (overflow !== 1'b0 || nwords1 !== 6'd0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b n1=%0d, want 0 0", overflow, nwords1);
    end
`ifdef LOADER_OVFL_CNT_EN
    checks++;
    if (ovfl_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ovfl_cnt_clear: got %0d, want 0", ovfl_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) beat(32'h0000_0100 + i, 1'b0, 2'd3);
    s_valid = 1'b1; s_data = 32'h0000_01ff; s_last = 1'b0; reset = 1'b1;
    step();  // no write may appear after this edge
    reset = 1'b0; s_valid = 1'b0;
    model_clear();
    checks++;
    if (nwords1 !== 6'd0 || en_proc !== 1'b0 || bx_o !== 2'd0 || overflow !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got n1=%0d en=%b bx=%0d ovf=%b ready=%b, want 0 0 0 0 1",
               nwords1, en_proc, bx_o, overflow, s_ready);
    end
    beat(32'h0000_0077, 1'b1, 2'd1);  // single-beat event, must land at addr 0
    step();
    checks++;
    if (nwords1 !== 6'd1 || bx_o !== 2'd1 || en_proc !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: got n1=%0d bx=%0d en=%b, want 1 1 1", nwords1, bx_o, en_proc);
    end
    end_event();
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 4; i++) begin
      beat(32'h8000_00a0 + i, (i == 3), 2'd2);
      if (i < 3) step();
    end
    step();
    checks++;
    if (nwords2 !== 6'd4 || nwords1 !== 6'd0 || en_proc !== 1'b1) begin
      errors++;
      $display("FAIL toggle_run: got n2=%0d n1=%0d en=%b, want 4 0 1", nwords2, nwords1, en_proc);
    end
    end_event();
  endtask

  task automatic test_back_to_back();
    beat(32'h0000_0001, 1'b0, 2'd1);
    beat(32'h8000_0002, 1'b1, 2'd3);
    step();
    checks++;
    if (bx_o !== 2'd1 || overflow !== 1'b0 || en_proc !== 1'b1) begin
      errors++;
      $display("FAIL b2b_run1: got bx=%0d ovf=%b en=%b, want 1 0 1", bx_o, overflow, en_proc);
    end
    end_event();
    beat(32'h0000_0003, 1'b0, 2'd3);
    beat(32'h0000_0004, 1'b0, 2'd0);
    beat(32'h8000_0005, 1'b1, 2'd1);
    step();
    checks++;
    if (bx_o !== m_bx || overflow !== 1'b0 || nwords1 !== 6'd2 || nwords2 !== 6'd1 || en_proc !== 1'b1) begin
      errors++;
      $display("FAIL b2b_run2: got bx=%0d ovf=%b n1=%0d n2=%0d en=%b, want 3 0 2 1 1",
               bx_o, overflow, nwords1, nwords2, en_proc);
    end
    end_event();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_run_hold();
    test_overflow();
    test_reset_mid();
    test_toggle();
    test_back_to_back();
    step(); step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending writes, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
